// File: rtl/serial_tx_ctrl_if.sv
// Parallel word handshake into the serial transmitter: source drives data/valid, transmitter drives ready.
// Valid/ready only; the source holds tx_data stable until the word is accepted.
interface serial_tx_ctrl_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );
endinterface

// File: rtl/serial_tx_ctrl.sv
// Serial framer: start bit, DATA_BITS LSB-first, optional even parity (SERIAL_TX_PARITY_EN), stop bit.
// Latency: start bit on serial_out the cycle after accept; every output is registered.
// Backpressure: tx_ready only in IDLE or the final stop cycle; the word is latched at accept.
module serial_tx_ctrl #(
    parameter int DATA_BITS  = 8,
    parameter int BIT_PERIOD = 10,
    parameter int CNT_BITS   = 4
) (
    input  logic            clk,
    input  logic            n_rst,
    serial_tx_ctrl_if.slave tx,
    output logic            serial_out,
    output logic            busy,
    output logic            frame_done
);

    localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CNT_BITS-1:0] TMR_ONE  = CNT_BITS'(1);
    localparam logic [CNT_BITS-1:0] TMR_LAST = CNT_BITS'(BIT_PERIOD);
    localparam logic [IDX_W-1:0]    IDX_LAST = IDX_W'(DATA_BITS - 1);

`ifdef SERIAL_TX_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;
`endif

    state_t                 state_q, state_d;
    logic [CNT_BITS-1:0]    tmr_q, tmr_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   serial_d;
    logic                   busy_d;
    logic                   done_d;
    logic                   ready_d;
    logic                   bit_end;
    logic                   accept;
`ifdef SERIAL_TX_PARITY_EN
    logic                   par_q, par_d;
`endif

    assign bit_end = (tmr_q == TMR_LAST);
    assign accept  = tx.tx_valid && tx.tx_ready;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= ST_IDLE;
            tmr_q      <= '0;
            idx_q      <= '0;
            shift_q    <= '0;
            serial_out <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            tx.tx_ready <= 1'b1;
`ifdef SERIAL_TX_PARITY_EN
            par_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            tmr_q      <= tmr_d;
            idx_q      <= idx_d;
            shift_q    <= shift_d;
            serial_out <= serial_d;
            busy       <= busy_d;
            frame_done <= done_d;
            tx.tx_ready <= ready_d;
`ifdef SERIAL_TX_PARITY_EN
            par_q      <= par_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        idx_d   = idx_q;
        shift_d = shift_q;
`ifdef SERIAL_TX_PARITY_EN
        par_d   = par_q;
`endif

        if (state_q != ST_IDLE) begin
            tmr_d = bit_end ? TMR_ONE : tmr_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_START;
                    tmr_d   = TMR_ONE;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    state_d = ST_DATA;
                    idx_d   = '0;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (idx_q == IDX_LAST) begin
`ifdef SERIAL_TX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
`ifdef SERIAL_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_end) begin
                    state_d = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                // A word accepted in the final stop cycle starts its frame with no idle gap.
                if (bit_end) begin
                    if (accept) begin
                        state_d = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                        tmr_d   = '0;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                tmr_d   = '0;
            end
        endcase

        if (accept) begin
            shift_d = tx.tx_data;
`ifdef SERIAL_TX_PARITY_EN
            par_d   = ^tx.tx_data;
`endif
        end
    end

    // Outputs are decoded from the next state so each register matches the state it accompanies.
    always_comb begin
        serial_d = 1'b1;
        case (state_d)
            ST_START:  serial_d = 1'b0;
            ST_DATA:   serial_d = shift_d[0];
`ifdef SERIAL_TX_PARITY_EN
            ST_PARITY: serial_d = par_d;
`endif
            default:   serial_d = 1'b1;
        endcase
        busy_d  = (state_d != ST_IDLE);
        done_d  = (state_d == ST_STOP) && (tmr_d == TMR_LAST);
        ready_d = (state_d == ST_IDLE) || done_d;
    end

    a_done_line_high: assert property (@(posedge clk) disable iff (!n_rst)
        frame_done |-> (serial_out && tx.tx_ready && busy));

    a_ready_idle: assert property (@(posedge clk) disable iff (!n_rst)
        !busy |-> (tx.tx_ready && serial_out));

endmodule

// File: tb/tb_serial_tx_ctrl.sv
// Bench for serial_tx_ctrl: literal frame table, hand sequences for back-to-back and async reset,
// then random traffic against a per-cycle expected-waveform queue.
module tb_serial_tx_ctrl;

    localparam int DB = 8;
    localparam int BP = 4;
    localparam int CB = 4;
`ifdef SERIAL_TX_PARITY_EN
    localparam int NBITS = DB + 3;
`else
    localparam int NBITS = DB + 2;
`endif
    localparam int FLEN = NBITS * BP;

    logic clk   = 1'b0;
    logic n_rst = 1'b1;
    logic serial_out;
    logic busy;
    logic frame_done;

    serial_tx_ctrl_if #(.DATA_BITS(DB)) tx_if ();

    serial_tx_ctrl #(
        .DATA_BITS (DB),
        .BIT_PERIOD(BP),
        .CNT_BITS  (CB)
    ) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .tx        (tx_if),
        .serial_out(serial_out),
        .busy      (busy),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // line_np: line bits in transmit order (bit 0 = start), parity omitted.
    typedef struct {
        logic [7:0] data;
        logic [9:0] line_np;
        logic       par;
    } vec_t;

    vec_t vecs[6];

    function automatic logic vec_bit(input vec_t v, input int p);
`ifdef SERIAL_TX_PARITY_EN
        if (p < DB + 1) return v.line_np[p];
        if (p == DB + 1) return v.par;
        return 1'b1;
`else
        return v.line_np[p];
`endif
    endfunction

    task automatic check_idle(input string tag);
        chk({tag, "_line"},  serial_out,     1);
        chk({tag, "_busy"},  busy,           0);
        chk({tag, "_ready"}, tx_if.tx_ready, 1);
        chk({tag, "_done"},  frame_done,     0);
    endtask

    // Entered at the negedge of the first frame cycle; leaves at the negedge of the last one.
    task automatic check_frame(input vec_t v, input bit scramble);
        for (int c = 0; c < FLEN; c++) begin
            chk("frm_line",  serial_out,     vec_bit(v, c / BP));
            chk("frm_busy",  busy,           1);
            chk("frm_ready", tx_if.tx_ready, (c == FLEN - 1));
            chk("frm_done",  frame_done,     (c == FLEN - 1));
            if (scramble) begin
                tx_if.tx_valid = (c < FLEN - 1) ? 1'($urandom) : 1'b0;
                tx_if.tx_data  = 8'($urandom);
            end
            if (c < FLEN - 1) @(negedge clk);
        end
    endtask

    typedef struct packed {
        logic ser;
        logic bsy;
        logic rdy;
        logic dn;
    } cyc_t;

    localparam cyc_t IDLE_CYC = 4'b1010;
    cyc_t exp_q[$];

    task automatic push_frame(input logic [7:0] d);
        logic bits[$];
        bit   last;
        bits.push_back(1'b0);
        for (int i = 0; i < DB; i++) bits.push_back(d[i]);
`ifdef SERIAL_TX_PARITY_EN
        bits.push_back(^d);
`endif
        bits.push_back(1'b1);
        for (int b = 0; b < bits.size(); b++) begin
            for (int t = 0; t < BP; t++) begin
                last = (b == bits.size() - 1) && (t == BP - 1);
                exp_q.push_back({bits[b], 1'b1, last, last});
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        cyc_t cur;
        bit   rdy;
        bit   vld;
        logic [7:0] d;

        vecs[0] = '{data: 8'hA5, line_np: 10'b1101001010, par: 1'b0};
        vecs[1] = '{data: 8'h07, line_np: 10'b1000001110, par: 1'b1};
        vecs[2] = '{data: 8'h00, line_np: 10'b1000000000, par: 1'b0};
        vecs[3] = '{data: 8'hFF, line_np: 10'b1111111110, par: 1'b0};
        vecs[4] = '{data: 8'h80, line_np: 10'b1100000000, par: 1'b1};
        vecs[5] = '{data: 8'h3C, line_np: 10'b1001111000, par: 1'b0};

        tx_if.tx_valid = 1'b0;
        tx_if.tx_data  = '0;

        // Reset state, then a quiet idle stretch.
        #1 n_rst = 1'b0;
        #3 check_idle("rst");
        @(negedge clk);
        @(negedge clk);
        n_rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_idle("idle");
        end

        // Single frames from the table; source data is altered right after accept.
        for (int i = 0; i < 6; i++) begin
            v = vecs[i];
            tx_if.tx_valid = 1'b1;
            tx_if.tx_data  = v.data;
            @(negedge clk);
            tx_if.tx_valid = 1'b0;
            tx_if.tx_data  = ~v.data;
            check_frame(v, 1'b0);
            @(negedge clk);
            check_idle("post");
        end

        // Valid toggling and data churn while busy.
        tx_if.tx_valid = 1'b1;
        tx_if.tx_data  = vecs[0].data;
        @(negedge clk);
        check_frame(vecs[0], 1'b1);
        @(negedge clk);
        check_idle("scr1");
        @(negedge clk);
        check_idle("scr2");

        // Back-to-back frames with valid held high.
        tx_if.tx_valid = 1'b1;
        tx_if.tx_data  = vecs[2].data;
        @(negedge clk);
        tx_if.tx_data  = vecs[3].data;
        check_frame(vecs[2], 1'b0);
        @(negedge clk);
        tx_if.tx_valid = 1'b0;
        check_frame(vecs[3], 1'b0);
        @(negedge clk);
        check_idle("b2b");

        // Asynchronous reset in the middle of data bit 3.
        tx_if.tx_valid = 1'b1;
        tx_if.tx_data  = 8'h00;
        @(negedge clk);
        tx_if.tx_valid = 1'b0;
        repeat (BP + 3 * BP + 1) @(negedge clk);
        chk("pre_arst_line", serial_out, 0);
        chk("pre_arst_busy", busy,       1);
        #2 n_rst = 1'b0;
        #1 check_idle("arst");
        @(negedge clk);
        n_rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_idle("arst_rel");
        end

        // Random traffic against the expected-waveform queue.
        for (int k = 0; k < 3000; k++) begin
            cur = (exp_q.size() > 0) ? exp_q.pop_front() : IDLE_CYC;
            chk("rnd_line",  serial_out,     cur.ser);
            chk("rnd_busy",  busy,           cur.bsy);
            chk("rnd_ready", tx_if.tx_ready, cur.rdy);
            chk("rnd_done",  frame_done,     cur.dn);
            rdy = (exp_q.size() == 0);
            vld = ($urandom_range(0, 3) != 0);
            d   = 8'($urandom);
            tx_if.tx_valid = vld;
            tx_if.tx_data  = d;
            if (vld && rdy) push_frame(d);
            @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
